// File: rtl/stage2_decode.sv
// stage2_decode: decode stage of the multicycle CPU.
//   Captures the fetch-stage cache output into the IR and the MDR. Holds the
//   2**REG_AW-entry register file and latches the rs/rt operands into A/B.
//   Presents the decoded fields, the extended immediate and the instruction PC.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears IR, MDR, A, B, PC and the RF
//   control[21:0]  control word: [14] IRWrite, [13] RegWrite, [11] RegDst, [10] ExtOp
//   instr_data_in  instruction/data from the fetch stage cache
//   current_pc     PC from the fetch stage
//   wb_data        register-file write-back data
//   ir_out         Instruction Register
//   mdr_out        Memory Data Register (reloads every edge)
//   data_a/data_b  A/B operand registers (RF[rs]/RF[rt], reload every edge)
//   imm_ext        IR[15:0] sign-extended (ExtOp=1) or zero-extended (ExtOp=0)
//   opcode/funct   IR[31:26] / IR[5:0]
//   instr_pc       PC captured together with the IR
// Optional feature:
//   REG_BYPASS_EN  adds a write-first bypass from wb_data into A/B when the
//                  RF write address matches rs/rt (and is not r0).
module stage2_decode #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [21:0]       control,
  input  logic [DATA_W-1:0] instr_data_in,
  input  logic [31:0]       current_pc,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [31:0]       imm_ext,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [31:0]       instr_pc
);

  localparam int unsigned RF_DEPTH = 2 ** REG_AW;

  logic ir_write;
  logic reg_write;
  logic reg_dst;
  logic ext_op;

  assign ir_write  = control[14];
  assign reg_write = control[13];
  assign reg_dst   = control[11];
  assign ext_op    = control[10];

  // Remaining control bits belong to other stages.
  logic unused_control;
  assign unused_control = ^{control[21:15], control[12], control[9:0]};

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rf_q [RF_DEPTH];

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] waddr;
  logic              rf_we;

  // All field decoding uses the IR currently held, so a write issued in the
  // same cycle as IRWrite targets the old instruction's rd/rt.
  assign rs    = ir_q[21 +: REG_AW];
  assign rt    = ir_q[16 +: REG_AW];
  assign rd    = ir_q[11 +: REG_AW];
  assign waddr = reg_dst ? rd : rt;
  assign rf_we = reg_write && (waddr != '0);

  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    if (ir_write) begin
      ir_d = instr_data_in;
      pc_d = current_pc;
    end
  end

  always_comb begin
    a_d = rf_q[rs];
    b_d = rf_q[rt];
`ifdef REG_BYPASS_EN
    if (rf_we && (waddr == rs)) a_d = wb_data;
    if (rf_we && (waddr == rt)) b_d = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      mdr_q <= instr_data_in;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // r0 is never written, so it reads 0 without a read-side mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[waddr] <= wb_data;
    end
  end

  assign ir_out   = ir_q;
  assign mdr_out  = mdr_q;
  assign data_a   = a_q;
  assign data_b   = b_q;
  assign instr_pc = pc_q;
  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign imm_ext  = ext_op ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0000, ir_q[15:0]};

endmodule
